// File: rtl/ws281x_pixel_tx.sv
// ws281x_pixel_tx
//   Serialises whole pixel words onto a WS281x one-wire LED data line.
//   Bits go out MSB first. Each bit lasts T_BIT clocks: the line is high for
//   T1H clocks for a '1' and T0H clocks for a '0', then low for the rest of
//   the bit. When a frame ends, the block holds the line low for RESET_CYCLES
//   clocks so the strip latches. One instance drives one strip.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset (starts a full latch period)
//   pix_data   : pixel word, MSB transmitted first
//   pix_last   : marks pix_data as the last pixel of the frame
//   pix_valid  : pix_data / pix_last are valid
//   pix_ready  : a pixel can be accepted this cycle (combinational)
//   dout       : registered strip data line
//   busy       : block is not idle
//   latch_done : one-cycle pulse when a latch period completes
//   underrun   : one-cycle pulse when a pixel ends with nothing queued behind
//                it and pix_last was not set
module ws281x_pixel_tx #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int T_BIT          = 125,
  parameter int T0H            = 24,
  parameter int T1H            = 60,
  parameter int RESET_CYCLES   = 2500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      pix_last,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic                      dout,
  output logic                      busy,
  output logic                      latch_done,
  output logic                      underrun
);

  localparam int CNT_MAX = (T_BIT > RESET_CYCLES) ? T_BIT : RESET_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;

  localparam logic [CW-1:0] TBIT_LAST  = CW'(T_BIT - 1);
  localparam logic [CW-1:0] T0H_LAST   = CW'(T0H - 1);
  localparam logic [CW-1:0] T1H_LAST   = CW'(T1H - 1);
  localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [BW-1:0] BIDX_LAST  = BW'(BITS_PER_PIXEL - 1);

  // Timing parameters that would give a malformed waveform stop elaboration.
  if (BITS_PER_PIXEL < 1) begin : g_chk_bpp
    $error("ws281x_pixel_tx: BITS_PER_PIXEL must be >= 1");
  end
  if (T0H < 1 || T0H >= T1H) begin : g_chk_t0h
    $error("ws281x_pixel_tx: T0H must satisfy 1 <= T0H < T1H");
  end
  if (T1H >= T_BIT) begin : g_chk_t1h
    $error("ws281x_pixel_tx: T1H must be < T_BIT");
  end
  if (RESET_CYCLES < 1) begin : g_chk_reset
    $error("ws281x_pixel_tx: RESET_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t                    state_q, state_n;
  logic [CW-1:0]             cnt_q, cnt_n;
  logic [BW-1:0]             bidx_q, bidx_n;
  logic [BITS_PER_PIXEL-1:0] shreg_q, shreg_n;
  logic                      last_q, last_n;
  logic                      dout_q, dout_n;
  logic                      latch_done_q, latch_done_n;
  logic                      underrun_q, underrun_n;

  logic                      final_cycle;
  logic                      accept;
  logic [CW-1:0]             txh_last;

  // Last clock of the last bit of the current pixel.
  assign final_cycle = (cnt_q == TBIT_LAST) && (bidx_q == BIDX_LAST);

  // A follow-on pixel is only taken in the very last cycle of the current
  // one, so rising edges stay exactly T_BIT apart across pixel boundaries.
  assign pix_ready = (state_q == IDLE) ||
                     ((state_q == SHIFT) && final_cycle && !last_q);
  assign accept    = pix_valid && pix_ready;
  assign busy      = (state_q != IDLE);

  // The current bit sits in the MSB of the shift register.
  assign txh_last  = shreg_q[BITS_PER_PIXEL-1] ? T1H_LAST : T0H_LAST;

  assign dout       = dout_q;
  assign latch_done = latch_done_q;
  assign underrun   = underrun_q;

  // Reset lands in LATCH so a bit truncated by reset is always followed by a
  // full latch gap before the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LATCH;
      cnt_q        <= '0;
      bidx_q       <= '0;
      shreg_q      <= '0;
      last_q       <= 1'b0;
      dout_q       <= 1'b0;
      latch_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      bidx_q       <= bidx_n;
      shreg_q      <= shreg_n;
      last_q       <= last_n;
      dout_q       <= dout_n;
      latch_done_q <= latch_done_n;
      underrun_q   <= underrun_n;
    end
  end

  // Next-state logic. Acceptance of a pixel is handled once after the case
  // statement because it looks the same from IDLE and from a pixel boundary.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    bidx_n       = bidx_q;
    shreg_n      = shreg_q;
    last_n       = last_q;
    dout_n       = dout_q;
    latch_done_n = 1'b0;
    underrun_n   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_n  = '0;
        dout_n = 1'b0;
      end

      SHIFT: begin
        if (cnt_q == TBIT_LAST) begin
          if (bidx_q != BIDX_LAST) begin
            shreg_n = shreg_q << 1;
            bidx_n  = bidx_q + 1'b1;
            cnt_n   = '0;
            dout_n  = 1'b1;
          end else if (last_q) begin
            state_n = LATCH;
            cnt_n   = '0;
            dout_n  = 1'b0;
          end else if (!pix_valid) begin
            state_n    = IDLE;
            cnt_n      = '0;
            dout_n     = 1'b0;
            underrun_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
          // Dropping here leaves the line high for exactly TxH cycles.
          if (cnt_q == txh_last) begin
            dout_n = 1'b0;
          end
        end
      end

      LATCH: begin
        dout_n = 1'b0;
        if (cnt_q == RESET_LAST) begin
          state_n      = IDLE;
          cnt_n        = '0;
          latch_done_n = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      default: begin
        state_n = LATCH;
        cnt_n   = '0;
        dout_n  = 1'b0;
      end
    endcase

    if (accept) begin
      state_n = SHIFT;
      shreg_n = pix_data;
      last_n  = pix_last;
      bidx_n  = '0;
      cnt_n   = '0;
      dout_n  = 1'b1;
    end
  end

endmodule

// File: tb/tb_ws281x_pixel_tx.sv
// tb_ws281x_pixel_tx
//   Directed bench for ws281x_pixel_tx. Instance dut_a uses the default
//   timing (24 bits, 125/24/60, 2500-cycle latch); dut_b uses a 32-bit word
//   with 63/15/35 timing and a 300-cycle latch. Only one instance is out of
//   reset at a time, so both share the pixel inputs.
module tb_ws281x_pixel_tx;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [31:0] pix_data = '0;
  logic        pix_last = 1'b0;
  logic        pix_valid = 1'b0;
  logic        sel = 1'b0;

  logic dout_a, ready_a, busy_a, ld_a, ur_a;
  logic dout_b, ready_b, busy_b, ld_b, ur_b;
  logic m_dout, m_ready, m_busy, m_ld, m_ur;

  int total = 0;
  int bad   = 0;

  logic dout_tr  [0:8703];
  logic ready_tr [0:8703];
  logic busy_tr  [0:8703];
  logic ld_tr    [0:8703];
  logic ur_tr    [0:8703];

  always #5 clk = ~clk;

  ws281x_pixel_tx dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .pix_data   (pix_data[23:0]),
    .pix_last   (pix_last),
    .pix_valid  (pix_valid),
    .pix_ready  (ready_a),
    .dout       (dout_a),
    .busy       (busy_a),
    .latch_done (ld_a),
    .underrun   (ur_a)
  );

  ws281x_pixel_tx #(
    .BITS_PER_PIXEL (32),
    .T_BIT          (63),
    .T0H            (15),
    .T1H            (35),
    .RESET_CYCLES   (300)
  ) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .pix_valid  (pix_valid),
    .pix_ready  (ready_b),
    .dout       (dout_b),
    .busy       (busy_b),
    .latch_done (ld_b),
    .underrun   (ur_b)
  );

  assign m_dout  = sel ? dout_b  : dout_a;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_ld    = sel ? ld_b    : ld_a;
  assign m_ur    = sel ? ur_b    : ur_a;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic last);
    pix_data  = data;
    pix_last  = last;
    pix_valid = 1'b1;
  endtask

  // Records one sample per cycle, each just after a rising edge. Index 0 is
  // the cycle right after the edge that accepts the pixel being presented.
  task automatic capture(input int n, input int change_at, input logic [31:0] new_data,
                         input logic new_last, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dout_tr[i]  = m_dout;
      ready_tr[i] = m_ready;
      busy_tr[i]  = m_busy;
      ld_tr[i]    = m_ld;
      ur_tr[i]    = m_ur;
      if (i == change_at) begin
        pix_data = new_data;
        pix_last = new_last;
      end
      if (i == drop_at) pix_valid = 1'b0;
    end
  endtask

  function automatic int countHigh(input int which, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      case (which)
        0: c += int'(ld_tr[i]);
        1: c += int'(ur_tr[i]);
        default: c += int'(ready_tr[i]);
      endcase
    end
    return c;
  endfunction

  function automatic int firstLatch(input int n);
    for (int i = 0; i < n; i++) if (ld_tr[i]) return i;
    return -1;
  endfunction

  // Checks leading-high run and total high time of every bit window.
  task automatic checkBits(input string tag, input int base, input int nbits, input int tbit,
                           input logic [31:0] pattern, input int t0h, input int t1h);
    for (int k = 0; k < nbits; k++) begin
      int exp_h = pattern[nbits-1-k] ? t1h : t0h;
      int start = base + k * tbit;
      int run = 0;
      int tot = 0;
      logic still = 1'b1;
      for (int j = 0; j < tbit; j++) begin
        if (dout_tr[start+j]) tot++;
        if (still && dout_tr[start+j]) run++;
        else still = 1'b0;
      end
      checkOutput($sformatf("%s_bit%0d_run", tag, nbits-1-k), run, exp_h);
      checkOutput($sformatf("%s_bit%0d_total", tag, nbits-1-k), tot, exp_h);
    end
  endtask

  // Called at the negedge where reset is released: the line must stay low
  // and not ready for rc cycles, then latch_done pulses once.
  task automatic checkLatch(input string tag, input int rc);
    int any_ready = 0;
    int any_dout  = 0;
    int any_ld    = 0;
    int not_busy  = 0;
    for (int i = 1; i < rc; i++) begin
      @(negedge clk);
      any_ready += int'(m_ready);
      any_dout  += int'(m_dout);
      any_ld    += int'(m_ld);
      not_busy  += int'(!m_busy);
    end
    checkOutput({tag, "_ready_low"}, any_ready, 0);
    checkOutput({tag, "_dout_low"}, any_dout, 0);
    checkOutput({tag, "_no_early_latch"}, any_ld, 0);
    checkOutput({tag, "_busy_held"}, not_busy, 0);
    @(negedge clk);
    checkOutput({tag, "_latch_done"}, int'(m_ld), 1);
    checkOutput({tag, "_ready_after"}, int'(m_ready), 1);
    checkOutput({tag, "_idle_busy"}, int'(m_busy), 0);
    @(negedge clk);
    checkOutput({tag, "_latch_pulse_end"}, int'(m_ld), 0);
  endtask

  initial begin
    // Power-on reset, dut_b stays in reset until its own test.
    repeat (3) @(negedge clk);
    checkOutput("rst_dout", int'(m_dout), 0);
    checkOutput("rst_ready", int'(m_ready), 0);
    checkOutput("rst_busy", int'(m_busy), 1);
    checkOutput("rst_latch_done", int'(m_ld), 0);
    checkOutput("rst_underrun", int'(m_ur), 0);
    rst_a = 1'b0;
    checkLatch("por", 2500);

    // Single pixel 0x800001 closing its frame.
    applyStimulus(32'h0080_0001, 1'b1);
    capture(5502, -1, '0, 1'b0, 0);
    checkOutput("single_rise_latency", int'(dout_tr[0]), 1);
    checkBits("single", 0, 24, 125, 32'h0080_0001, 24, 60);
    checkOutput("single_latch_index", firstLatch(5502), 5500);
    checkOutput("single_latch_count", countHigh(0, 0, 5501), 1);
    checkOutput("single_ready_low", countHigh(2, 0, 5499), 0);
    checkOutput("single_latch_dout", int'(dout_tr[4000]), 0);
    checkOutput("single_ready_idle", int'(ready_tr[5500]), 1);

    // Back-to-back: 0xFFFFFF then 0x000000 with valid held throughout.
    applyStimulus(32'h00FF_FFFF, 1'b0);
    capture(8502, 0, 32'h0000_0000, 1'b1, 3000);
    checkOutput("b2b_ready_before", int'(ready_tr[2998]), 0);
    checkOutput("b2b_ready_window", int'(ready_tr[2999]), 1);
    checkOutput("b2b_ready_after", int'(ready_tr[3000]), 0);
    checkOutput("b2b_no_gap_low", int'(dout_tr[2999]), 0);
    checkOutput("b2b_no_gap_rise", int'(dout_tr[3000]), 1);
    checkBits("b2b_p0", 0, 24, 125, 32'h00FF_FFFF, 24, 60);
    checkBits("b2b_p1", 3000, 24, 125, 32'h0000_0000, 24, 60);
    checkOutput("b2b_no_underrun", countHigh(1, 0, 8501), 0);
    checkOutput("b2b_latch_index", firstLatch(8502), 8500);

    // Underrun: a non-last pixel with nothing behind it.
    applyStimulus(32'h0012_3456, 1'b0);
    capture(3002, -1, '0, 1'b0, 0);
    checkBits("urun", 0, 24, 125, 32'h0012_3456, 24, 60);
    checkOutput("urun_busy_before", int'(busy_tr[2999]), 1);
    checkOutput("urun_pulse", int'(ur_tr[3000]), 1);
    checkOutput("urun_pulse_count", countHigh(1, 0, 3001), 1);
    checkOutput("urun_idle", int'(busy_tr[3000]), 0);
    checkOutput("urun_dout", int'(dout_tr[3000]), 0);
    checkOutput("urun_no_latch", countHigh(0, 0, 3001), 0);
    checkOutput("urun_ready", int'(ready_tr[3001]), 1);

    // Reset while bit 5 is high.
    applyStimulus(32'h0000_0000, 1'b0);
    capture(631, -1, '0, 1'b0, 0);
    checkOutput("midrst_high_before", int'(dout_tr[630]), 1);
    #1 rst_a = 1'b1;
    #1;
    checkOutput("midrst_async_dout", int'(m_dout), 0);
    checkOutput("midrst_ready", int'(m_ready), 0);
    checkOutput("midrst_busy", int'(m_busy), 1);
    @(negedge clk);
    rst_a = 1'b0;
    checkLatch("midrst", 2500);

    // 32-bit instance with shorter timing.
    rst_a = 1'b1;
    sel   = 1'b1;
    rst_b = 1'b0;
    checkLatch("ovr_rst", 300);
    applyStimulus(32'hA5A5_A5A5, 1'b1);
    capture(2318, -1, '0, 1'b0, 0);
    checkOutput("ovr_rise_latency", int'(dout_tr[0]), 1);
    checkBits("ovr", 0, 32, 63, 32'hA5A5_A5A5, 15, 35);
    checkOutput("ovr_latch_index", firstLatch(2318), 2316);
    checkOutput("ovr_latch_count", countHigh(0, 0, 2317), 1);
    checkOutput("ovr_no_underrun", countHigh(1, 0, 2317), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws281x_pixel_tx.md
Name: ws281x_pixel_tx

Overview:
- Parametrised successor to the single-bit WS2811 PWM encoder.
- Accepts whole pixel words over a valid/ready handshake and serialises them MSB-first onto the one-wire LED data line.
- Generates the latch (reset) low period at end of frame, with per-bit timing set by parameters.
- Sits between the frame/pixel sequencer and the strip output pin; one instance per strip.

Parameters:
- BITS_PER_PIXEL, 24, bits per pixel word (24 = GRB, 32 = GRBW); must be >= 1.
- T_BIT, 125, clk cycles per bit period (2.5 us at 50 MHz).
- T0H, 24, high cycles for a '0' bit; must satisfy 1 <= T0H < T1H.
- T1H, 60, high cycles for a '1' bit; must satisfy T1H < T_BIT.
- RESET_CYCLES, 2500, low cycles of the latch period (50 us at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous active-high reset.
- pix_data  input  BITS_PER_PIXEL  pixel word, MSB transmitted first.
- pix_last  input  1  qualifies pix_data: this is the last pixel of the frame.
- pix_valid  input  1  pix_data/pix_last valid.
- pix_ready  output  1  block can accept a pixel this cycle.
- dout  output  1  registered strip data line.
- busy  output  1  state != IDLE.
- latch_done  output  1  one-cycle pulse when a latch period completes.
- underrun  output  1  one-cycle pulse when a pixel ends with no follow-on and no pix_last.

Behaviour:
- States: IDLE, SHIFT, LATCH.
- Internals: cnt (width $clog2 of max(T_BIT, RESET_CYCLES)), bit index, shift register, last flag.
- Reset (async, rst=1):
  - dout=0, latch_done=0, underrun=0.
  - State=LATCH, cnt=0; pix_ready=0 and busy=1 while in reset.
  - After rst falls, a full RESET_CYCLES low period runs, then latch_done pulses and the state goes to IDLE.
  - This guarantees a latch gap after any mid-bit truncation.
- Handshake:
  - Transfer occurs on a clk edge with pix_valid && pix_ready.
  - pix_ready is combinational: 1 in IDLE; 1 in SHIFT only in the final cycle of the final bit (cnt==T_BIT-1, bit index==BITS_PER_PIXEL-1) when the current last flag is 0; 0 otherwise.
  - pix_data and pix_last must stay stable while pix_valid=1 and pix_ready=0.
- Accept:
  - Load the shift register and last flag, set bit index=0 and cnt=0, go to SHIFT.
  - Set dout<=1 on the same edge, so dout rises in the cycle after acceptance (1 cycle latency).
- SHIFT, per bit:
  - cnt increments every cycle from 0 to T_BIT-1.
  - dout<=0 at the edge where cnt+1 == TxH, where TxH=T1H if the current bit is 1, else T0H.
  - dout is therefore high for exactly TxH cycles and low for T_BIT-TxH cycles.
- Bit boundary (cnt==T_BIT-1, not the final bit): shift, increment bit index, cnt<=0, dout<=1.
- Pixel boundary (cnt==T_BIT-1, final bit):
  - last flag=1: go to LATCH, cnt<=0, dout stays 0; any pix_valid is not accepted.
  - Else if pix_valid: accept as above. Rising edges stay exactly T_BIT apart across the pixel boundary, with no gap cycle.
  - Else: go to IDLE, underrun<=1 for one cycle, dout stays 0.
- LATCH:
  - dout=0 for RESET_CYCLES cycles, counted from the first cycle in LATCH.
  - At cnt==RESET_CYCLES-1: latch_done<=1 for one cycle, go to IDLE.
- IDLE: dout=0, cnt held at 0, busy=0.
- Simultaneous events: the LATCH exit and a new pix_valid never overlap. A pixel is accepted at the earliest in the cycle after latch_done, once pix_ready=1 in IDLE.
- Parameter violations (T0H>=T1H, T1H>=T_BIT, zero values) are caught by an elaboration-time check that raises $error.

Test Plan:
- Reset: hold rst 3 cycles, release -> dout=0 and pix_ready=0 for 2500 cycles, latch_done pulses once, then pix_ready=1, busy=0.
- Single pixel 0x800001 with pix_last=1 -> dout rises 1 cycle after accept.
  - Bit 23: high 60 cycles, low 65. Bits 22..1: high 24, low 101. Bit 0: high 60.
  - Then 2500 low cycles and a latch_done pulse 24*125+2500 cycles after accept.
- Back-to-back: pixels 0xFFFFFF (pix_last=0) then 0x000000 (pix_last=1), valid held -> second pixel accepted at cycle 24*125-1 after the first accept.
  - Rising edges stay every 125 cycles across the boundary.
  - underrun never asserts.
- Underrun: one pixel with pix_last=0, pix_valid dropped -> underrun pulses once after bit 0, state IDLE, dout=0, no latch_done.
- Reset mid-bit: assert rst while dout=1 in bit 5 -> dout=0 asynchronously (same cycle), then a full 2500-cycle latch before pix_ready=1.
- Overrides: BITS_PER_PIXEL=32, T_BIT=63, T0H=15, T1H=35, RESET_CYCLES=300 with pixel 0xA5A5A5A5, pix_last=1 -> 32 bits with the 1,0,1,0,0,1,0,1 high-time pattern (35/15), then a 300-cycle latch.
